// File: rtl/cmap_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cmap_writeback_sequencer
// Brief    : Per-tile driver for the channel-map buffer. Accepts a tile cmap,
//            pulses the buffer load, walks the done index 1..WIDTH and issues
//            one write-back request per (optionally unmasked) channel.
// Revision : 1.0 - initial release
// ============================================================================
module cmap_writeback_sequencer #(
  parameter int WIDTH     = 16,
  parameter int SKIP_ZERO = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tile_valid,
  output logic             o_tile_ready,
  input  logic [WIDTH-1:0] i_tile_cmap,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_cmap_data,
  output logic             o_cmap_load,
  output logic [4:0]       o_done,
  input  logic             i_cmap_bit,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic [3:0]       o_wb_channel,
  output logic             o_wb_mask,
  output logic             o_tile_done,
  output logic [4:0]       o_wb_count
);

  localparam logic [4:0] c_LAST = 5'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SCAN   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cmap_data;
  logic             r_tile_ready;
  logic             r_cmap_load;
  logic [4:0]       r_done;
  logic             r_tile_done;
  logic [4:0]       r_wb_count;
  logic [4:0]       r_cnt;

  logic             w_scan;
  logic             w_req;
  logic             w_mask;
  logic             w_hs;
  logic             w_adv;
  logic             w_last;
  logic [4:0]       w_cnt_nxt;

  // A channel is requested when its buffer bit is set, or always when skipping is disabled.
  // The mask is simply the buffer bit; with skipping enabled a request implies bit=1.
  assign w_scan    = (r_state == S_SCAN);
  assign w_req     = w_scan && ((SKIP_ZERO == 0) || i_cmap_bit);
  assign w_mask    = w_req && i_cmap_bit;
  assign w_hs      = w_req && i_wb_ready;
  assign w_adv     = w_hs || (w_scan && !w_req);
  assign w_last    = (r_done == c_LAST);
  assign w_cnt_nxt = r_cnt + {4'd0, (w_hs && w_mask)};

  assign o_tile_ready = r_tile_ready;
  assign o_cmap_data  = r_cmap_data;
  assign o_cmap_load  = r_cmap_load;
  assign o_done       = r_done;
  assign o_tile_done  = r_tile_done;
  assign o_wb_count   = r_wb_count;
  assign o_wb_valid   = w_req;
  assign o_wb_mask    = w_mask;
  // done=16 wraps to channel 15 in the 4-bit subtraction; done=0 reports channel 0.
  assign o_wb_channel = (r_done == 5'd0) ? 4'd0 : (r_done[3:0] - 4'd1);

  // Tile sequencing FSM; abort overrides everything except reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cmap_data  <= '0;
      r_tile_ready <= 1'b1;
      r_cmap_load  <= 1'b0;
      r_done       <= 5'd0;
      r_tile_done  <= 1'b0;
      r_wb_count   <= 5'd0;
      r_cnt        <= 5'd0;
    end else if (i_abort) begin
      r_state      <= S_IDLE;
      r_tile_ready <= 1'b1;
      r_cmap_load  <= 1'b0;
      r_done       <= 5'd0;
      r_tile_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_tile_valid && r_tile_ready) begin
            r_cmap_data  <= i_tile_cmap;
            r_cnt        <= 5'd0;
            r_tile_ready <= 1'b0;
            r_cmap_load  <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cmap_load <= 1'b0;
          r_done      <= 5'd1;
          r_state     <= S_SCAN;
        end
        S_SCAN: begin
          if (w_adv) begin
            r_cnt <= w_cnt_nxt;
            if (w_last) begin
              r_done      <= 5'd0;
              r_tile_done <= 1'b1;
              r_wb_count  <= w_cnt_nxt;
              r_state     <= S_FINISH;
            end else begin
              r_done <= r_done + 5'd1;
            end
          end
        end
        S_FINISH: begin
          r_tile_done  <= 1'b0;
          r_tile_ready <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state      <= S_IDLE;
          r_tile_ready <= 1'b1;
          r_cmap_load  <= 1'b0;
          r_done       <= 5'd0;
          r_tile_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmap_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmap_writeback_sequencer
// Brief    : Bench for cmap_writeback_sequencer. Instance 0 skips zero
//            channels, instance 1 requests every channel. A small buffer
//            model per instance feeds cmap_bit back from done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmap_writeback_sequencer;

  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       tv, ab, wr;
  logic [1:0][15:0] tcm;
  wire  [1:0]       tr, ld, cb, wv, wm, tdn;
  wire  [1:0][15:0] cd;
  wire  [1:0][4:0]  dn, wc;
  wire  [1:0][3:0]  ch;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] prev_cnt [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [15:0] snap;
    cmap_writeback_sequencer #(.WIDTH(W), .SKIP_ZERO(k == 0 ? 1 : 0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_tile_valid(tv[k]), .o_tile_ready(tr[k]), .i_tile_cmap(tcm[k]),
      .i_abort(ab[k]), .o_cmap_data(cd[k]), .o_cmap_load(ld[k]),
      .o_done(dn[k]), .i_cmap_bit(cb[k]), .o_wb_valid(wv[k]),
      .i_wb_ready(wr[k]), .o_wb_channel(ch[k]), .o_wb_mask(wm[k]),
      .o_tile_done(tdn[k]), .o_wb_count(wc[k])
    );
    // Buffer model: snapshot on load, indexed combinational read, 0 when done=0
    always_ff @(posedge clk) if (ld[k]) snap <= cd[k];
    assign cb[k] = (dn[k] == 5'd0) ? 1'b0 : snap[dn[k][3:0] - 4'd1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input int k);
    chk($sformatf("rst_ready[%0d]", k), 32'(tr[k]), 32'd1);
    chk($sformatf("rst_load[%0d]", k), 32'(ld[k]), 32'd0);
    chk($sformatf("rst_done[%0d]", k), 32'(dn[k]), 32'd0);
    chk($sformatf("rst_valid[%0d]", k), 32'(wv[k]), 32'd0);
    chk($sformatf("rst_chan[%0d]", k), 32'(ch[k]), 32'd0);
    chk($sformatf("rst_mask[%0d]", k), 32'(wm[k]), 32'd0);
    chk($sformatf("rst_tdone[%0d]", k), 32'(tdn[k]), 32'd0);
    chk($sformatf("rst_count[%0d]", k), 32'(wc[k]), 32'd0);
    chk($sformatf("rst_cdata[%0d]", k), 32'(cd[k]), 32'd0);
  endtask

  // Runs one tile on instance k starting at the current cycle (cycle 0).
  // The expected per-cycle timeline is built up front from the channel rules:
  // each visited channel costs one cycle plus its wb_ready-low stall cycles.
  task automatic run_tile(input int k, input logic [15:0] cm, input int bp_ch,
                          input int bp_len, input bit rnd, input int ab_cyc,
                          input int rst_cyc, input int exp_td, input int exp_cnt);
    logic [4:0] e_done  [64];
    logic       e_valid [64];
    logic [3:0] e_ch    [64];
    logic       e_mask  [64];
    logic       e_rdy   [64];
    int t, td, last, cnt, stalls;
    bit req;
    for (int i = 0; i < 64; i++) begin
      e_done[i] = 0; e_valid[i] = 0; e_ch[i] = 0; e_mask[i] = 0;
      e_rdy[i] = 1'($urandom);
    end
    t = 2;
    cnt = 0;
    for (int c = 0; c < W; c++) begin
      req = (k == 1) || cm[c];
      cnt += int'(cm[c]);
      if (req) begin
        if (c == bp_ch)   stalls = bp_len;
        else if (rnd)     stalls = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        else              stalls = 0;
        for (int s = 0; s <= stalls; s++) begin
          e_done[t] = 5'(c + 1); e_valid[t] = 1'b1; e_ch[t] = 4'(c);
          e_mask[t] = cm[c];     e_rdy[t] = (s == stalls);
          t++;
        end
      end else begin
        e_done[t] = 5'(c + 1);
        t++;
      end
    end
    td   = t;
    last = (ab_cyc >= 0) ? ab_cyc : ((rst_cyc >= 0) ? rst_cyc : td);

    // cycle 0: offer the tile; the sequencer must be idle
    tv[k] = 1'b1; tcm[k] = cm; wr[k] = e_rdy[0];
    @(negedge clk);
    chk("c0_ready", 32'(tr[k]), 32'd1);
    chk("c0_done", 32'(dn[k]), 32'd0);
    chk("c0_valid", 32'(wv[k]), 32'd0);
    chk("c0_tdone", 32'(tdn[k]), 32'd0);
    chk("c0_count", 32'(wc[k]), 32'(prev_cnt[k]));
    @(posedge clk); #1;
    tv[k] = 1'b0; tcm[k] = 16'($urandom);

    for (int cyc = 1; cyc <= last; cyc++) begin
      wr[k] = e_rdy[cyc];
      ab[k] = (cyc == ab_cyc);
      @(negedge clk);
      chk($sformatf("load c%0d", cyc), 32'(ld[k]), 32'(cyc == 1));
      chk($sformatf("ready c%0d", cyc), 32'(tr[k]), 32'd0);
      chk($sformatf("tdone c%0d", cyc), 32'(tdn[k]), 32'(cyc == td));
      chk($sformatf("done c%0d", cyc), 32'(dn[k]), 32'(e_done[cyc]));
      chk($sformatf("valid c%0d", cyc), 32'(wv[k]), 32'(e_valid[cyc]));
      if (e_valid[cyc]) begin
        chk($sformatf("chan c%0d", cyc), 32'(ch[k]), 32'(e_ch[cyc]));
        chk($sformatf("mask c%0d", cyc), 32'(wm[k]), 32'(e_mask[cyc]));
      end
      if (cyc == 1) chk("cdata", 32'(cd[k]), 32'(cm));
      if (cyc == td) chk("count", 32'(wc[k]), 32'(cnt));
      if (cyc == exp_td) begin
        chk("td_tbl", 32'(tdn[k]), 32'd1);
        chk("cnt_tbl", 32'(wc[k]), 32'(exp_cnt));
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk_reset(0);
        chk_reset(1);
        #1 rst_n = 1'b1;
        prev_cnt[0] = 0; prev_cnt[1] = 0;
      end
      @(posedge clk); #1;
      ab[k] = 1'b0;
    end
    if (ab_cyc < 0 && rst_cyc < 0) prev_cnt[k] = 5'(cnt);
  endtask

  typedef struct {
    int          k;
    logic [15:0] cm;
    int          bp_ch;
    int          bp_len;
    int          ab_cyc;
    int          rst_cyc;
    int          exp_td;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 16'hFFFF, -1, 0, -1, -1, 18, 16};
    vecs[1] = '{0, 16'hA5A5, -1, 0, -1, -1, 18, 8};
    vecs[2] = '{0, 16'h0003,  1, 3, -1, -1, 21, 2};
    vecs[3] = '{1, 16'h00F0, -1, 0, -1, -1, 18, 4};
    vecs[4] = '{0, 16'hFFFF, -1, 0,  6, -1, -1, 0};
    vecs[5] = '{0, 16'h0F0F, -1, 0, -1, -1, 18, 8};
    vecs[6] = '{0, 16'hFFFF, -1, 0, -1, 10, -1, 0};
    vecs[7] = '{0, 16'h0000, -1, 0, -1, -1, 18, 0};
    vecs[8] = '{1, 16'h0000, -1, 0, -1, -1, 18, 0};
    vecs[9] = '{1, 16'hFFFF, 15, 2, -1, -1, 20, 16};

    rst_n = 1'b0; tv = '0; ab = '0; wr = '0; tcm = '0;
    prev_cnt[0] = 0; prev_cnt[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_tile(vecs[i].k, vecs[i].cm, vecs[i].bp_ch, vecs[i].bp_len, 1'b0,
               vecs[i].ab_cyc, vecs[i].rst_cyc, vecs[i].exp_td, vecs[i].exp_cnt);

    for (int i = 0; i < 16; i++) begin
      int          k;
      logic [15:0] cm;
      int          abc;
      k   = int'($urandom_range(0, 1));
      cm  = 16'($urandom);
      if (i % 3 == 0) cm = cm & 16'($urandom);
      abc = (i % 5 == 4) ? int'($urandom_range(1, 17)) : -1;
      run_tile(k, cm, -1, 0, 1'b1, abc, -1, -1, 0);
    end

    @(negedge clk);
    chk("end_ready0", 32'(tr[0]), 32'd1);
    chk("end_ready1", 32'(tr[1]), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
